pwr_btn_ctrl: RTL and testbench

PWR_BTN_CTRL -- requirements
Module: pwr_btn_ctrl

---
 rtl/pwr_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 56 +++++
 rtl/pwr_btn_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pwr_btn_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pwr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwr_pkg
//  Description : Shared definitions for the power-button controller and the
//                power controller: register addresses, register bit
//                positions and press-FSM state encodings.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package pwr_pkg;

    // Register map
    localparam int unsigned ADDR_BTN_CTRL = 'h18;
    localparam int unsigned ADDR_BTN_STA  = 'h1A;

    // BTN_CTRL bit positions
    localparam int CTRL_BTN_EN_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // BTN_STA bit positions
    localparam int STA_DB_BIT      = 0;
    localparam int STA_SHORT_BIT   = 1;
    localparam int STA_LONG_BIT    = 2;
    localparam int STA_STATE_LSB   = 4;
    localparam int STA_STATE_MSB   = 6;

    // Press FSM, one-hot so the state field in BTN_STA is directly readable
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_HELD    = 3'b010,
        ST_LOCKOUT = 3'b100
    } btn_state_e;

endpackage : pwr_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : 2-FF synchronizer and tick-sampled debounce filter for an
//                asynchronous active-low push button.
//  Ports       : clk_i      - system clock
//                rst_i      - synchronous active-high reset
//                tick_i     - 1-cycle sample strobe (1 ms)
//                btn_n_i    - raw asynchronous button, active-low
//                btn_db_o   - debounced level, 1 = pressed
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic btn_n_i,
    output logic btn_db_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic [1:0]       sync_q;
    logic             db_q;
    logic [CNT_W-1:0] cnt_q;
    logic             w_raw;

    assign w_raw    = ~sync_q[1];
    assign btn_db_o = db_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;            // released
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_n_i};
            if (tick_i) begin
                if (w_raw == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == c_CNT_LAST) begin
                    // This tick completes the run of differing samples
                    db_q  <= w_raw;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule : btn_debounce
`default_nettype wire

// File: rtl/pwr_btn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwr_btn_ctrl
//  Description : Front-panel power button controller. Debounces the button,
//                classifies short / long presses and issues power-on,
//                forced-off and shutdown-interrupt requests. Exposes
//                BTN_CTRL / BTN_STA through a memory-mapped slave.
//  Ports       : clk_sys_i, rst_i          - clock, sync active-high reset
//                mm_s_addr_i/wdata_i/we_i  - register write side
//                mm_s_rdata_o              - combinational read data
//                pwr_btn_n_i               - raw button, active-low, async
//                pwr_on_i                  - system-on status
//                pwr_btn_on_o/off_o        - 1-cycle power requests
//                pwr_btn_irq_o             - level shutdown interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module pwr_btn_ctrl
    import pwr_pkg::*;
#(
    parameter int          MM_ADDR_WIDTH     = 8,
    parameter int          MM_DATA_WIDTH     = 16,
    parameter int          TICK_CYCLES       = 25_000,
    parameter int          DEBOUNCE_MS       = 20,
    parameter int          LONG_PRESS_MS     = 4000,
    parameter int unsigned REG_ADDR_BTN_CTRL = ADDR_BTN_CTRL,
    parameter int unsigned REG_ADDR_BTN_STA  = ADDR_BTN_STA
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_i,
    input  logic [MM_ADDR_WIDTH-1:0] mm_s_addr_i,
    input  logic [MM_DATA_WIDTH-1:0] mm_s_wdata_i,
    input  logic                     mm_s_we_i,
    output logic [MM_DATA_WIDTH-1:0] mm_s_rdata_o,
    input  logic                     pwr_btn_n_i,
    input  logic                     pwr_on_i,
    output logic                     pwr_btn_on_o,
    output logic                     pwr_btn_off_o,
    output logic                     pwr_btn_irq_o
);

    localparam int PRE_W  = $clog2(TICK_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_MS + 1);
    localparam logic [PRE_W-1:0]         c_TICK_LAST = PRE_W'(TICK_CYCLES - 1);
    localparam logic [HOLD_W-1:0]        c_LONG      = HOLD_W'(LONG_PRESS_MS);
    localparam logic [MM_ADDR_WIDTH-1:0] c_A_CTRL    = MM_ADDR_WIDTH'(REG_ADDR_BTN_CTRL);
    localparam logic [MM_ADDR_WIDTH-1:0] c_A_STA     = MM_ADDR_WIDTH'(REG_ADDR_BTN_STA);

    logic [PRE_W-1:0]  pre_q;
    logic              w_tick;
    logic              w_db;
    logic              db_prev_q;
    btn_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              on_q, on_d, off_q, off_d;
    logic              w_set_short, w_set_long;
    logic              btn_en_q, irq_en_q, short_q, long_q, irq_q;
    logic              w_wr_ctrl, w_wr_sta;
    logic              unused_wdata;

    // ------------------------------------------------------------ ms prescaler
    assign w_tick = (pre_q == c_TICK_LAST);

    always_ff @(posedge clk_sys_i) begin
        if (rst_i)       pre_q <= '0;
        else if (w_tick) pre_q <= '0;
        else             pre_q <= pre_q + 1'b1;
    end

    btn_debounce #(
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_debounce (
        .clk_i    (clk_sys_i),
        .rst_i    (rst_i),
        .tick_i   (w_tick),
        .btn_n_i  (pwr_btn_n_i),
        .btn_db_o (w_db)
    );

    // ---------------------------------------------------------------- press FSM
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        on_d        = 1'b0;
        off_d       = 1'b0;
        w_set_short = 1'b0;
        w_set_long  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                if (w_db && !db_prev_q) state_d = ST_HELD;
            end
            ST_HELD: begin
                // Long-press threshold takes precedence over a same-cycle release
                if (hold_q == c_LONG) begin
                    state_d = ST_LOCKOUT;
                    if (pwr_on_i && btn_en_q) begin
                        off_d      = 1'b1;
                        w_set_long = 1'b1;
                    end
                end else if (!w_db && db_prev_q) begin
                    state_d = ST_IDLE;
                    if (!pwr_on_i) on_d        = btn_en_q;
                    else           w_set_short = btn_en_q;
                end else if (w_tick) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (!w_db && db_prev_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- registers
    assign w_wr_ctrl    = mm_s_we_i && (mm_s_addr_i == c_A_CTRL);
    assign w_wr_sta     = mm_s_we_i && (mm_s_addr_i == c_A_STA);
    assign unused_wdata = ^mm_s_wdata_i;

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            db_prev_q <= 1'b0;
            on_q      <= 1'b0;
            off_q     <= 1'b0;
            btn_en_q  <= 1'b1;
            irq_en_q  <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            db_prev_q <= w_db;
            on_q      <= on_d;
            off_q     <= off_d;
            if (w_wr_ctrl) begin
                btn_en_q <= mm_s_wdata_i[CTRL_BTN_EN_BIT];
                irq_en_q <= mm_s_wdata_i[CTRL_IRQ_EN_BIT];
            end
            // Set has priority over a coincident write-1-clear
            short_q <= w_set_short |
                       (short_q & ~(w_wr_sta & mm_s_wdata_i[STA_SHORT_BIT]));
            long_q  <= w_set_long |
                       (long_q & ~(w_wr_sta & mm_s_wdata_i[STA_LONG_BIT]));
            irq_q   <= short_q & irq_en_q;
        end
    end

    assign pwr_btn_on_o  = on_q;
    assign pwr_btn_off_o = off_q;
    assign pwr_btn_irq_o = irq_q;

    // ------------------------------------------------------------- read mux
    always_comb begin
        mm_s_rdata_o = '0;
        if (mm_s_addr_i == c_A_CTRL) begin
            mm_s_rdata_o[CTRL_BTN_EN_BIT] = btn_en_q;
            mm_s_rdata_o[CTRL_IRQ_EN_BIT] = irq_en_q;
        end else if (mm_s_addr_i == c_A_STA) begin
            mm_s_rdata_o[STA_DB_BIT]                    = w_db;
            mm_s_rdata_o[STA_SHORT_BIT]                 = short_q;
            mm_s_rdata_o[STA_LONG_BIT]                  = long_q;
            mm_s_rdata_o[STA_STATE_MSB:STA_STATE_LSB]   = state_q;
        end
    end

endmodule : pwr_btn_ctrl
`default_nettype wire

// File: tb/tb_pwr_btn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwr_btn_ctrl
//  Description : Self-checking bench for pwr_btn_ctrl with short timing
//                parameters (25-clock tick, 4-tick debounce, 40-tick long).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwr_btn_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] rdata;
    logic        btn_n;
    logic        pwr_on;
    logic        on_o, off_o, irq_o;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int on_cnt  = 0;
    int off_cnt = 0;
    int last_on = 0;
    int last_off = 0;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [10];

    pwr_btn_ctrl #(
        .MM_ADDR_WIDTH (8),
        .MM_DATA_WIDTH (16),
        .TICK_CYCLES   (25),
        .DEBOUNCE_MS   (4),
        .LONG_PRESS_MS (40)
    ) dut (
        .clk_sys_i     (clk),
        .rst_i         (rst),
        .mm_s_addr_i   (addr),
        .mm_s_wdata_i  (wdata),
        .mm_s_we_i     (we),
        .mm_s_rdata_o  (rdata),
        .pwr_btn_n_i   (btn_n),
        .pwr_on_i      (pwr_on),
        .pwr_btn_on_o  (on_o),
        .pwr_btn_off_o (off_o),
        .pwr_btn_irq_o (irq_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (on_o)  begin on_cnt  <= on_cnt + 1;  last_on  <= cyc; end
        if (off_o) begin off_cnt <= off_cnt + 1; last_off <= cyc; end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [15:0] exp);
        addr = a;
        #1;
        chk(nm, int'(rdata), int'(exp));
    endtask

    initial begin
        int base_on, base_off, t_ref, db_seen;

        vecs[0] = '{1'b0, 8'h18, 16'h0000, 16'h0001, "ctrl_reset"};
        vecs[1] = '{1'b0, 8'h1A, 16'h0000, 16'h0010, "sta_reset"};
        vecs[2] = '{1'b0, 8'h00, 16'h0000, 16'h0000, "unmapped_00"};
        vecs[3] = '{1'b1, 8'h18, 16'hFFFF, 16'h0003, "ctrl_write_all"};
        vecs[4] = '{1'b1, 8'h19, 16'h0000, 16'h0000, "unmapped_19_wr"};
        vecs[5] = '{1'b0, 8'h18, 16'h0000, 16'h0003, "ctrl_after_unmapped_wr"};
        vecs[6] = '{1'b1, 8'h1A, 16'hFFFF, 16'h0010, "sta_w1c_readonly"};
        vecs[7] = '{1'b1, 8'h18, 16'h0002, 16'h0002, "ctrl_irq_only"};
        vecs[8] = '{1'b0, 8'hFF, 16'h0000, 16'h0000, "unmapped_ff"};
        vecs[9] = '{1'b1, 8'h18, 16'h0001, 16'h0001, "ctrl_restore"};

        rst = 1'b1; btn_n = 1'b1; pwr_on = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);
        chk("reset_on",  int'(on_o),  0);
        chk("reset_off", int'(off_o), 0);
        chk("reset_irq", int'(irq_o), 0);

        // Register access table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
            rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end

        // Short press while off -> power-on pulse after debounced release
        pwr_on = 1'b0;
        base_on = on_cnt;
        btn_n = 1'b0; wait_clk(300);
        btn_n = 1'b1; t_ref = cyc;
        wait_clk(200);
        chk("s1_on_pulses", on_cnt - base_on, 1);
        chk_range("s1_on_delay", last_on - t_ref, 75, 130);
        rd_chk("s1_sta", 8'h1A, 16'h0010);

        // Glitches shorter than the debounce window
        base_on = on_cnt; base_off = off_cnt; db_seen = 0;
        addr = 8'h1A;
        for (int i = 0; i < 600; i++) begin
            btn_n = ((i % 60) < 30) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (rdata[0]) db_seen = 1;
        end
        btn_n = 1'b1;
        wait_clk(150);
        chk("s2_db_stays_low", db_seen, 0);
        chk("s2_no_pulses", (on_cnt - base_on) + (off_cnt - base_off), 0);

        // Short press while on -> SHORT + interrupt, then W1C
        pwr_on = 1'b1;
        wr(8'h18, 16'h0003);
        base_on = on_cnt;
        btn_n = 1'b0; wait_clk(300);
        btn_n = 1'b1; wait_clk(200);
        rd_chk("s3_sta_short", 8'h1A, 16'h0012);
        chk("s3_irq_set", int'(irq_o), 1);
        chk("s3_no_on_pulse", on_cnt - base_on, 0);
        wr(8'h1A, 16'h0002);
        wait_clk(1);
        chk("s3_irq_cleared", int'(irq_o), 0);
        rd_chk("s3_sta_cleared", 8'h1A, 16'h0010);

        // Long press while on -> forced off, LOCKOUT until release
        base_off = off_cnt;
        btn_n = 1'b0; t_ref = cyc;
        wait_clk(1300);
        rd_chk("s4_sta_lockout", 8'h1A, 16'h0045);
        wait_clk(200);
        btn_n = 1'b1;
        chk("s4_off_pulses", off_cnt - base_off, 1);
        chk_range("s4_off_time", last_off - t_ref, 1000, 1200);
        wait_clk(200);
        rd_chk("s4_sta_after", 8'h1A, 16'h0014);
        chk("s4_irq_low", int'(irq_o), 0);
        wr(8'h1A, 16'h0004);
        rd_chk("s4_long_w1c", 8'h1A, 16'h0010);

        // Button disabled: level still tracked, no requests or flags
        wr(8'h18, 16'h0000);
        pwr_on = 1'b0;
        base_on = on_cnt; base_off = off_cnt;
        btn_n = 1'b0; wait_clk(300);
        rd_chk("s5_db_held", 8'h1A, 16'h0021);
        btn_n = 1'b1; wait_clk(200);
        rd_chk("s5_db_released", 8'h1A, 16'h0010);
        pwr_on = 1'b1;
        btn_n = 1'b0; wait_clk(1300);
        rd_chk("s5_lockout_no_long", 8'h1A, 16'h0041);
        btn_n = 1'b1; wait_clk(200);
        chk("s5_no_pulses", (on_cnt - base_on) + (off_cnt - base_off), 0);
        wr(8'h18, 16'h0003);

        // Reset during HELD aborts without a pulse
        pwr_on = 1'b0;
        base_on = on_cnt;
        btn_n = 1'b0; wait_clk(200);
        rd_chk("s6_held", 8'h1A, 16'h0021);
        rst = 1'b1; btn_n = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        chk("s6_outputs_low", int'({on_o, off_o, irq_o}), 0);
        rd_chk("s6_ctrl_reset", 8'h18, 16'h0001);
        rd_chk("s6_sta_reset", 8'h1A, 16'h0010);
        wait_clk(200);
        chk("s6_no_pulse", on_cnt - base_on, 0);

        // Button held through reset release counts as a fresh press
        base_on = on_cnt;
        btn_n = 1'b0; wait_clk(200);
        rst = 1'b1; wait_clk(1);
        rst = 1'b0;
        rd_chk("s6b_db_cleared", 8'h1A, 16'h0010);
        wait_clk(300);
        rd_chk("s6b_new_press", 8'h1A, 16'h0021);
        btn_n = 1'b1; wait_clk(200);
        chk("s6b_one_pulse", on_cnt - base_on, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pwr_btn_ctrl
`default_nettype wire
